// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
// Row/column codes: key code = row*4 + col.
package keypad_pkg;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_DEB_PRESS,
        KP_PRESSED,
        KP_DEB_REL
    } kp_state_t;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam logic [3:0] KP_NONE_COLS = 4'b1111;

    function automatic logic [3:0] kp_encode(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Lowest-numbered low (pressed) column; 0 when none is low.
    function automatic logic [1:0] kp_first_col(input logic [3:0] cols);
        logic [1:0] idx;
        idx = '0;
        for (int c = KP_COLS - 1; c >= 0; c--) begin
            if (!cols[c]) idx = 2'(c);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Row rotation, per-slot column sampling and full-scan snapshot for the keypad.
// scan_done/scan_found/scan_code are valid together on the last cycle of the row-3 slot.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cols,
    output logic [3:0] row_out,
    output logic       scan_done,
    output logic       scan_found,
    output logic [3:0] scan_code
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW-1:0] slot_cnt;
    logic [1:0]    row;
    logic          found_acc;
    logic [3:0]    code_acc;
    logic          slot_end;
    logic          row_hit;
    logic [3:0]    row_code;

    assign slot_end   = (slot_cnt == SW'(SCAN_DIV - 1));
    assign row_hit    = (cols != KP_NONE_COLS);
    assign row_code   = kp_encode(row, kp_first_col(cols));
    assign scan_done  = slot_end && (row == 2'(KP_ROWS - 1));
    // The earliest row wins, so the live row only matters if nothing was found yet.
    assign scan_found = found_acc || row_hit;
    assign scan_code  = found_acc ? code_acc : row_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            row       <= '0;
            row_out   <= 4'b1110;
            found_acc <= 1'b0;
            code_acc  <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            row      <= row + 2'd1;
            row_out  <= {row_out[2:0], row_out[3]};
            if (scan_done) begin
                found_acc <= 1'b0;
                code_acc  <= '0;
            end else if (row_hit && !found_acc) begin
                found_acc <= 1'b1;
                code_acc  <= row_code;
            end
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: column synchroniser, debounce FSM and key strobe.
// Optional auto-repeat strobes are enabled with the KEYPAD_REPEAT_EN macro.
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_SCANS = 4,
    parameter int REP_SCANS = 64
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(DEB_SCANS + 1);

    if (SCAN_DIV < 4 || DEB_SCANS < 2 || REP_SCANS < 1) begin : g_param_check
        $error("keypad_scan_4x4: parameter out of range");
    end

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic          scan_done;
    logic          scan_found;
    logic [3:0]    scan_code;
    kp_state_t     state;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_inc;
    logic [3:0]    cand;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync1 <= KP_NONE_COLS;
            sync2 <= KP_NONE_COLS;
        end else begin
            sync1 <= col_in;
            sync2 <= sync1;
        end
    end

    keypad_row_scanner #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scanner (
        .clk       (sys_clk),
        .rst_n     (reset),
        .cols      (sync2),
        .row_out   (row_out),
        .scan_done (scan_done),
        .scan_found(scan_found),
        .scan_code (scan_code)
    );

    assign cnt_inc = cnt + 1'b1;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REP_SCANS + 1);
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_inc;
    assign rep_inc = rep_cnt + 1'b1;
`endif

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state     <= KP_IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    KP_IDLE: begin
                        if (scan_found) begin
                            state <= KP_DEB_PRESS;
                            cand  <= scan_code;
                            cnt   <= DW'(1);
                        end
                    end
                    KP_DEB_PRESS: begin
                        if (!scan_found) begin
                            state <= KP_IDLE;
                        end else if (scan_code != cand) begin
                            cand <= scan_code;
                            cnt  <= DW'(1);
                        end else if (cnt_inc == DW'(DEB_SCANS)) begin
                            state     <= KP_PRESSED;
                            key_code  <= cand;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    KP_PRESSED: begin
                        // A different key while held is ignored until a full release.
                        if (!scan_found) begin
                            state <= KP_DEB_REL;
                            cnt   <= DW'(1);
                        end
                    end
                    KP_DEB_REL: begin
                        if (scan_found) begin
                            state <= KP_PRESSED;
                        end else if (cnt_inc == DW'(DEB_SCANS)) begin
                            state    <= KP_IDLE;
                            key_held <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= KP_IDLE;
                endcase
`ifdef KEYPAD_REPEAT_EN
                // Held in IDLE/DEB_PRESS at zero, so entry into PRESSED starts a fresh count.
                if (state == KP_PRESSED || state == KP_DEB_REL) begin
                    if (rep_inc == RW'(REP_SCANS)) begin
                        rep_cnt   <= '0;
                        key_valid <= 1'b1;
                    end else begin
                        rep_cnt <= rep_inc;
                    end
                end else begin
                    rep_cnt <= '0;
                end
`endif
            end
        end
    end

endmodule

// File: doc/keypad_scan_4x4.md
Name: keypad_scan_4x4

Overview:
- Input-side counterpart of the multiplexed 7-segment scan driver: drives a 4x4 matrix keypad row by row and reads the column lines.
- Synchronises and debounces the column lines, then emits a 4-bit key code with a one-cycle valid strobe.
- Feeds front-panel entry (coin/amount selection) for the soda-machine top, running on sys_clk with no derived clock.

Parameters:
- SCAN_DIV, 1000, sys_clk cycles per row slot (>=4).
- DEB_SCANS, 4, consecutive identical full scans needed to accept a press or a release (>=2).
- REP_SCANS, 64, full scans between auto-repeat strobes (used only with the optional feature).

Ports:
- sys_clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- col_in  input  4  keypad columns; active-low (pulled up externally), asynchronous.
- row_out  output  4  row drive; active-low one-hot.
- key_code  output  4  last accepted key, = row*4 + col.
- key_valid  output  1  one-cycle strobe when a key is accepted.
- key_held  output  1  high while the accepted key is considered pressed.

Behaviour:
- Reset values: row_out=4'b1110, key_code=0, key_valid=0, key_held=0, state IDLE, all counters 0, synchroniser flops all 1.
- col_in passes through a 2-FF synchroniser reset to 4'b1111.
- Slot counter counts 0..SCAN_DIV-1.
- On the last cycle of a slot, the synchronised columns are sampled for the current row; on the next cycle the row advances 0->1->2->3->0 (wraps).
- Scan snapshot: built over rows 0..3.
  - Found = any low column.
  - Code = first hit by lowest row, then lowest column; additional simultaneous keys are ignored.
  - The snapshot is evaluated at the end of the row-3 slot ("scan boundary").
- FSM, evaluated only at scan boundaries:
  - IDLE: found -> DEB_PRESS, cand=code, cnt=1.
  - DEB_PRESS:
    - found && code==cand -> cnt++; when cnt reaches DEB_SCANS -> PRESSED.
    - found && code!=cand -> cand=code, cnt=1.
    - not found -> IDLE.
  - PRESSED: not found -> DEB_REL, cnt=1. A different key found stays PRESSED (release required first).
  - DEB_REL:
    - not found -> cnt++; when cnt reaches DEB_SCANS -> IDLE.
    - found -> PRESSED, with no new strobe.
- On the transition DEB_PRESS->PRESSED, in the same cycle:
  - key_code<=cand, key_valid<=1 for exactly one sys_clk cycle, key_held<=1.
- key_held clears on DEB_REL->IDLE.
- key_code holds its value until the next accepted press.
- Press latency: key_valid rises 1 cycle after the DEB_SCANS-th qualifying scan boundary (plus 2 synchroniser cycles to first sampling).
- Reset asserted mid-operation clears everything immediately. After deassertion, scanning restarts at row 0, slot 0.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined: a repeat counter runs while in PRESSED or DEB_REL, counting scan boundaries.
  - After REP_SCANS boundaries, key_valid pulses again with the unchanged key_code; the counter then restarts.
  - The counter is cleared on entry to PRESSED from DEB_PRESS.
- Undefined: exactly one key_valid per press; no repeat counter is synthesised.

Decomposition:
- Package keypad_pkg holds:
  - enum kp_state_t {KP_IDLE, KP_DEB_PRESS, KP_PRESSED, KP_DEB_REL};
  - constant KP_ROWS=4, KP_COLS=4, KP_NONE_COLS=4'b1111;
  - function kp_encode(row, col) returning a 4-bit code.
- One sub-module, keypad_row_scanner. It owns the slot counter, row_out rotation, sample strobe, snapshot accumulation and scan_done pulse.
- The top level owns the synchroniser, FSM and outputs.

Test Plan (SCAN_DIV=4, DEB_SCANS=3, REP_SCANS=5; scan = 16 cycles):
- Reset: hold reset=0, then release -> row_out=1110, key_valid=0, key_held=0; row_out cycles 1110,1101,1011,0111 every 4 cycles.
- Clean press of row2/col1 (col_in[1]=0 only while row_out[2]=0) for 5 scans -> single key_valid pulse, key_code=9, key_held=1; after release for 3 scans -> key_held=0.
- Bounce: toggle row1/col3 pressed/unpressed each scan for 6 scans -> no key_valid; then hold steady 3 scans -> one pulse, key_code=7.
- Two keys held (row0/col2 and row3/col0) -> key_code=2. Then release row0/col2 while row3/col0 stays held -> no new pulse, key_held stays 1.
- Reset asserted during DEB_PRESS after 2 scans -> outputs cleared at once. After deassertion, the held key needs 3 fresh scans before key_valid.
- With KEYPAD_REPEAT_EN: hold key 15 for 20 scans -> first pulse after 3 scans, then a pulse every 5 scans (4 pulses total), all key_code=15. Without the macro -> 1 pulse.
